// File: rtl/wired_pkg.sv
// Shared types for the wired beat splitter.
package wired_pkg;

  // Splitter control state: IDLE holds no word, BUSY holds a word with beats pending.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/wired_beat_splitter.sv
// Wide-to-narrow splitter: captures one wide word and emits it as 1..RATIO
// narrow beats with index and last markers, one beat per cycle.
module wired_beat_splitter
  import wired_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 4,
  localparam int IN_WIDTH = OUT_WIDTH * RATIO,
  localparam int CNT_W    = $clog2(RATIO + 1),
  localparam int IDX_W    = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inport_valid,
  output logic                 inport_ready,
  input  logic [IN_WIDTH-1:0]  inport_payload,
  input  logic [CNT_W-1:0]     inport_beats,
  output logic                 outport_valid,
  input  logic                 outport_ready,
  output logic [OUT_WIDTH-1:0] outport_payload,
  output logic                 outport_last,
  output logic [IDX_W-1:0]     outport_index
);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   index_q, index_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0]    word_q, word_d;

  logic             busy;
  logic             last;
  logic             accept;
  logic [CNT_W-1:0] beats_norm;

  // Output view of held state; inport_ready is the only path from outport_ready.
  always_comb begin
    busy            = (state_q == BUSY);
    last            = busy && (CNT_W'(index_q) == (count_q - CNT_W'(1)));
    outport_valid   = busy;
    outport_last    = last;
    outport_index   = index_q;
    outport_payload = word_q[index_q];
    inport_ready    = !busy || (outport_ready && last);
    accept          = inport_valid && inport_ready;
  end

  // Out-of-range beat counts (0 or above RATIO) mean a full word.
  always_comb begin
    beats_norm = inport_beats;
    if (inport_beats == '0 || inport_beats > CNT_W'(RATIO)) begin
      beats_norm = CNT_W'(RATIO);
    end
  end

  // Next-state: capture on accept, otherwise advance or retire the held word.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    word_d  = word_q;
    if (accept) begin
      state_d = BUSY;
      index_d = '0;
      count_d = beats_norm;
      word_d  = inport_payload;
    end else if (busy && outport_ready) begin
      if (last) begin
        state_d = IDLE;
        index_d = '0;
      end else begin
        index_d = index_q + IDX_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      count_q <= CNT_W'(RATIO);
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_wired_beat_splitter.sv
// Directed self-checking bench for wired_beat_splitter (OUT_WIDTH=32, RATIO=4).
module tb_wired_beat_splitter;

  localparam int OW = 32;
  localparam int R  = 4;
  localparam int IW = OW * R;
  localparam int CW = 3;
  localparam int XW = 2;

  logic          clk;
  logic          rst_n;
  logic          inport_valid;
  logic          inport_ready;
  logic [IW-1:0] inport_payload;
  logic [CW-1:0] inport_beats;
  logic          outport_valid;
  logic          outport_ready;
  logic [OW-1:0] outport_payload;
  logic          outport_last;
  logic [XW-1:0] outport_index;

  int errors = 0;
  int checks = 0;

  wired_beat_splitter #(.OUT_WIDTH(OW), .RATIO(R)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inport_valid   (inport_valid),
    .inport_ready   (inport_ready),
    .inport_payload (inport_payload),
    .inport_beats   (inport_beats),
    .outport_valid  (outport_valid),
    .outport_ready  (outport_ready),
    .outport_payload(outport_payload),
    .outport_last   (outport_last),
    .outport_index  (outport_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inport_valid = 1'b0; inport_payload = '0;
    inport_beats = '0; outport_ready = 1'b0;
    #2;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc=%0d got %b want 0", c, outport_valid); end
      checks++; if (inport_ready !== 1'b1) begin errors++; $display("FAIL reset_inready cyc=%0d got %b want 1", c, inport_ready); end
      checks++; if (outport_index !== 2'd0) begin errors++; $display("FAIL reset_index cyc=%0d got %0d want 0", c, outport_index); end
      checks++; if (outport_last !== 1'b0) begin errors++; $display("FAIL reset_last cyc=%0d got %b want 0", c, outport_last); end
      checks++; if (outport_payload !== 32'h0) begin errors++; $display("FAIL reset_payload cyc=%0d got %h want 0", c, outport_payload); end
    end
    rst_n = 1'b1;
  endtask

  // Capture one word with all-ready downstream and check every beat.
  task automatic test_full_word(input logic [IW-1:0] w, input logic [CW-1:0] b,
                                input int exp_n, input string name);
    logic [IW-1:0] wv;
    wv = w;
    inport_valid = 1'b1; inport_payload = w; inport_beats = b; outport_ready = 1'b1;
    checks++; if (inport_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready got %b want 1", name, inport_ready); end
    step();
    inport_valid = 1'b0;
    #1;
    for (int k = 0; k < exp_n; k++) begin
      checks++; if (outport_valid !== 1'b1) begin errors++; $display("FAIL %s_valid k=%0d got %b want 1", name, k, outport_valid); end
      checks++; if (outport_payload !== wv[k*OW +: OW]) begin errors++; $display("FAIL %s_payload k=%0d got %h want %h", name, k, outport_payload, wv[k*OW +: OW]); end
      checks++; if (outport_index !== XW'(k)) begin errors++; $display("FAIL %s_index k=%0d got %0d want %0d", name, k, outport_index, k); end
      checks++; if (outport_last !== (k == exp_n - 1)) begin errors++; $display("FAIL %s_last k=%0d got %b want %b", name, k, outport_last, (k == exp_n - 1)); end
      checks++; if (inport_ready !== (k == exp_n - 1)) begin errors++; $display("FAIL %s_inready k=%0d got %b want %b", name, k, inport_ready, (k == exp_n - 1)); end
      step();
    end
    checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL %s_done_valid got %b want 0", name, outport_valid); end
    checks++; if (outport_index !== 2'd0) begin errors++; $display("FAIL %s_done_index got %0d want 0", name, outport_index); end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] wa, wb;
    logic [OW-1:0] exp_p [6];
    logic [XW-1:0] exp_i [6];
    logic          exp_l [6];
    wa = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
    wb = 128'hDEADBEEF_CAFEF00D_B0B0B0B2_B0B0B0B1;
    exp_p = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4, 32'hB0B0B0B1, 32'hB0B0B0B2};
    exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    inport_valid = 1'b1; inport_payload = wa; inport_beats = 3'd4; outport_ready = 1'b1;
    step();
    inport_payload = wb; inport_beats = 3'd2;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (outport_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got %b want 1", k, outport_valid); end
      checks++; if (outport_payload !== exp_p[k]) begin errors++; $display("FAIL b2b_payload k=%0d got %h want %h", k, outport_payload, exp_p[k]); end
      checks++; if (outport_index !== exp_i[k]) begin errors++; $display("FAIL b2b_index k=%0d got %0d want %0d", k, outport_index, exp_i[k]); end
      checks++; if (outport_last !== exp_l[k]) begin errors++; $display("FAIL b2b_last k=%0d got %b want %b", k, outport_last, exp_l[k]); end
      checks++; if (inport_ready !== exp_l[k]) begin errors++; $display("FAIL b2b_inready k=%0d got %b want %b", k, inport_ready, exp_l[k]); end
      step();
      if (k == 3) inport_valid = 1'b0;
    end
    checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid got %b want 0", outport_valid); end
  endtask

  task automatic test_stall();
    logic [IW-1:0] w;
    logic          rdy   [5];
    logic [XW-1:0] exp_i [5];
    logic          exp_l [5];
    w = 128'h0000FFFF_C3C3C3C3_C2C2C2C2_C1C1C1C1;
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_i = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    inport_valid = 1'b1; inport_payload = w; inport_beats = 3'd3; outport_ready = 1'b1;
    step();
    inport_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      outport_ready = rdy[c];
      #1;
      checks++; if (outport_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %b want 1", c, outport_valid); end
      checks++; if (outport_index !== exp_i[c]) begin errors++; $display("FAIL stall_index c=%0d got %0d want %0d", c, outport_index, exp_i[c]); end
      checks++; if (outport_payload !== w[32*exp_i[c] +: 32]) begin errors++; $display("FAIL stall_payload c=%0d got %h want %h", c, outport_payload, w[32*exp_i[c] +: 32]); end
      checks++; if (outport_last !== exp_l[c]) begin errors++; $display("FAIL stall_last c=%0d got %b want %b", c, outport_last, exp_l[c]); end
      checks++; if (inport_ready !== (rdy[c] && exp_l[c])) begin errors++; $display("FAIL stall_inready c=%0d got %b want %b", c, inport_ready, rdy[c] && exp_l[c]); end
      step();
    end
    checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL stall_done_valid got %b want 0", outport_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [IW-1:0] w;
    w = 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1;
    inport_valid = 1'b1; inport_payload = w; inport_beats = 3'd4; outport_ready = 1'b1;
    step();
    inport_valid = 1'b0;
    checks++; if (outport_payload !== 32'hD1D1D1D1) begin errors++; $display("FAIL rmid_beat0 got %h want d1d1d1d1", outport_payload); end
    step();
    checks++; if (outport_index !== 2'd1) begin errors++; $display("FAIL rmid_beat1_index got %0d want 1", outport_index); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid got %b want 0", outport_valid); end
    checks++; if (inport_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_inready got %b want 1", inport_ready); end
    checks++; if (outport_index !== 2'd0) begin errors++; $display("FAIL rmid_async_index got %0d want 0", outport_index); end
    checks++; if (outport_payload !== 32'h0) begin errors++; $display("FAIL rmid_async_payload got %h want 0", outport_payload); end
    checks++; if (outport_last !== 1'b0) begin errors++; $display("FAIL rmid_async_last got %b want 0", outport_last); end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (outport_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid c=%0d got %b want 0", c, outport_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word(128'h44444444_33333333_22222222_11111111, 3'd4, 4, "four");
    test_back_to_back();
    test_stall();
    test_full_word(128'h5555_0003_5555_0002_5555_0001_5555_0000, 3'd0, 4, "beats0");
    test_full_word(128'h7777_0003_7777_0002_7777_0001_7777_0000, 3'd7, 4, "beats7");
    test_full_word(128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_12345678, 3'd1, 1, "beats1");
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound total run time in case stimulus stalls.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wired_beat_splitter.md
WIRED_BEAT_SPLITTER -- requirements
Module: wired_beat_splitter

Interface
REQ-001 Parameter OUT_WIDTH, default 32, width of one output beat in bits.
REQ-002 Parameter RATIO, default 4, maximum beats per input word; legal range 2..16.
REQ-003 Derived constant IN_WIDTH = OUT_WIDTH*RATIO; CNT_W = $clog2(RATIO+1); IDX_W = $clog2(RATIO).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 inport_valid  input  1  wide word offered.
REQ-007 inport_ready  output  1  wide word accepted when valid&ready.
REQ-008 inport_payload  input  IN_WIDTH  wide word; beat k = bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-009 inport_beats  input  CNT_W  beats to emit, 1..RATIO.
REQ-010 outport_valid  output  1  beat offered.
REQ-011 outport_ready  input  1  beat consumed when valid&ready.
REQ-012 outport_payload  output  OUT_WIDTH  current beat.
REQ-013 outport_last  output  1  current beat is final beat of its word.
REQ-014 outport_index  output  IDX_W  index k of current beat.

Function
REQ-015 Two states: IDLE (no word held), BUSY (word held, beats pending).
REQ-016 IDLE: inport_ready=1, outport_valid=0; on inport_valid, capture payload and beat count, index:=0, go BUSY.
REQ-017 BUSY: outport_valid=1; outport_payload = held beat[index]; outport_last = (index == count-1).
REQ-018 BUSY, outport_ready & !last: index increments by 1; held word unchanged.
REQ-019 BUSY, outport_ready & last: inport_ready=1 same cycle; if inport_valid, capture new word, index:=0, stay BUSY (no bubble); else go IDLE.
REQ-020 BUSY otherwise: inport_ready=0; all outputs held stable (valid, payload, last, index).
REQ-021 Latency: first beat visible the cycle after input acceptance; throughput one beat per cycle sustained across words.
REQ-022 inport_ready = IDLE | (BUSY & outport_ready & outport_last); combinational path outport_ready->inport_ready permitted; upstream register slice breaks it.
REQ-023 inport_beats of 0 or >RATIO treated as RATIO.
REQ-024 inport_beats=1: single beat with outport_last=1, index 0.
REQ-025 Beats past count never presented; unused high beats of payload ignored.
REQ-026 Outputs purely from registered state plus outport_ready (REQ-022 only); outport_payload is a mux of held register, no input-to-output combinational path.

Reset
REQ-027 rst_n low asynchronously forces IDLE, index=0, held count=RATIO, held word=0.
REQ-028 Reset values: outport_valid=0, outport_payload=0, outport_last=0, outport_index=0, inport_ready=1.
REQ-029 No word captured while rst_n low; reset mid-word discards remaining beats with no partial output afterwards.
REQ-030 First capture possible on first rising edge after rst_n deasserts.

Structure
REQ-031 State enum (IDLE/BUSY) typedef in shared package wired_pkg; CNT_W/IDX_W computed locally.
REQ-032 No sub-module; single flat module, held word register with enable, counter, 2-state FSM, beat mux.

Verification
REQ-033 Reset then idle: rst_n low 3 cycles -> outport_valid=0, inport_ready=1, index=0 throughout.
REQ-034 OUT_WIDTH=32,RATIO=4, word 0x44443333_22221111_ ... beats=4, outport_ready=1 -> 4 consecutive beats 0x...,index 0..3, last only on index 3.
REQ-035 Two words back-to-back, beats=4 then 2, ready=1 -> 6 beats in 6 consecutive cycles, no bubble, last on beats 4 and 6.
REQ-036 beats=3, outport_ready toggling 1,0,0,1,1 -> beat held stable during stalls, 3 beats delivered, inport_ready=0 until last accepted.
REQ-037 beats=0 and beats=7 (CNT_W=3) -> both emit 4 beats.
REQ-038 rst_n pulsed low after beat 1 of 4 -> outputs return to reset values asynchronously; no beats 2..4 ever appear.
